switching_block_layers: RTL and testbench



---
 rtl/lib_switchblock_pkg.sv | 29 ++
 rtl/switching_block_layers_block.sv | 99 +++++++++
 rtl/switching_block_layers.sv | 67 ++++++
 tb/tb_switching_block_layers.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// -----------------------------------------------------------------------------
// lib_switchblock_pkg
//   Shared constants and helpers for the three-layer DEM switching tree.
//   - INPUT_WIDTH : width of the input code and of every sub-code
//   - NUM_LAYERS  : depth of the binary splitting tree (one register per layer)
//   - NUM_OUTPUTS : number of leaf sub-codes (2**NUM_LAYERS)
//   - LFSR_WIDTH  : width of the per-block sign LFSR (used with DEM_LFSR_EN)
//   - lfsr_seed() : distinct non-zero seed for each block index
//   - lfsr_feedback() : Fibonacci feedback bit, taps 8,6,5,4
// -----------------------------------------------------------------------------
package lib_switchblock_pkg;

  localparam int INPUT_WIDTH = 16;
  localparam int NUM_LAYERS  = 3;
  localparam int NUM_OUTPUTS = 8;
  localparam int LFSR_WIDTH  = 8;

  // Block index 0..6 maps to seeds 1..7, so no LFSR can start in the
  // all-zero lock-up state.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_seed(input int block_index);
    return LFSR_WIDTH'(block_index + 1);
  endfunction

  // Taps 8,6,5,4 (1-based) give a maximal-length 8-bit sequence.
  function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] state);
    return state[7] ^ state[5] ^ state[4] ^ state[3];
  endfunction

endpackage

// File: rtl/switching_block_layers_block.sv
// -----------------------------------------------------------------------------
// switching_block
//   One DEM splitting element: registers a = ceil/floor(x/2) and b = x - a.
//   For even x both halves are equal; for odd x the extra LSB goes to a when
//   the sign bit is 0 and to b when it is 1, so a + b == x always.
//
//   Optional feature macro: DEM_LFSR_EN
//     defined   - sign is bit 0 of a per-block 8-bit Fibonacci LFSR that
//                 advances every cycle and resets to lfsr_seed(BLOCK_INDEX)
//     undefined - sign is a toggle bit t that flips on every odd input
//                 (first-order mismatch shaping)
//
// Ports
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-high reset (outputs and sign state to reset)
//   x_i      : input code
//   a_o, b_o : registered halves, a_o + b_o == previous-cycle x_i
// -----------------------------------------------------------------------------
module switching_block
  import lib_switchblock_pkg::*;
#(
  parameter int BLOCK_INDEX = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [INPUT_WIDTH-1:0] x_i,
  output logic [INPUT_WIDTH-1:0] a_o,
  output logic [INPUT_WIDTH-1:0] b_o
);

  localparam logic [LFSR_WIDTH-1:0] SEED = lfsr_seed(BLOCK_INDEX);

  logic [INPUT_WIDTH-1:0] half_dn;
  logic [INPUT_WIDTH-1:0] half_up;
  logic [INPUT_WIDTH-1:0] a_d, b_d;
  logic [INPUT_WIDTH-1:0] a_q, b_q;
  logic                   odd;
  logic                   sign;

  assign odd     = x_i[0];
  // For odd x, (x-1)/2 is a plain shift; (x+1)/2 is formed one bit wider so
  // x = 2^W-1 yields 2^(W-1) without wrapping.
  assign half_dn = x_i >> 1;
  assign half_up = INPUT_WIDTH'(({1'b0, x_i} + (INPUT_WIDTH + 1)'(1)) >> 1);

`ifdef DEM_LFSR_EN
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], lfsr_feedback(lfsr_q)};
  assign sign   = lfsr_q[0];

  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end
`else
  logic t_q, t_d;
  logic unused_seed;

  // The seed only matters for the LFSR build.
  assign unused_seed = ^SEED;

  // t flips on the same edge that registers the odd sample's halves.
  assign t_d  = odd ? ~t_q : t_q;
  assign sign = t_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) t_q <= 1'b0;
    else         t_q <= t_d;
  end
`endif

  // NOTE: defaults assigned first so every path drives a_d/b_d and no latch
  // is inferred.
  always_comb begin
    a_d = half_dn;
    b_d = half_dn;
    if (odd) begin
      if (!sign) a_d = half_up;
      else       b_d = half_up;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule

// File: rtl/switching_block_layers.sv
// -----------------------------------------------------------------------------
// switching_block_layers
//   Three-layer binary-tree DEM splitter. Seven switching_block instances
//   split each input code into eight sub-codes whose sum equals the input
//   sampled three edges earlier. One sample accepted per cycle, no handshake.
//
//   Optional feature macro: DEM_LFSR_EN (selects LFSR sign inside each block;
//   sum and latency are unchanged).
//
// Ports
//   clk_i                     : clock, rising edge
//   reset_i                   : synchronous active-high reset, flushes tree
//   x_in_i                    : unsigned input code
//   x_out3_1_o .. x_out3_8_o  : registered layer-3 sub-codes
// -----------------------------------------------------------------------------
module switching_block_layers
  import lib_switchblock_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [INPUT_WIDTH-1:0] x_in_i,
  output logic [INPUT_WIDTH-1:0] x_out3_1_o,
  output logic [INPUT_WIDTH-1:0] x_out3_2_o,
  output logic [INPUT_WIDTH-1:0] x_out3_3_o,
  output logic [INPUT_WIDTH-1:0] x_out3_4_o,
  output logic [INPUT_WIDTH-1:0] x_out3_5_o,
  output logic [INPUT_WIDTH-1:0] x_out3_6_o,
  output logic [INPUT_WIDTH-1:0] x_out3_7_o,
  output logic [INPUT_WIDTH-1:0] x_out3_8_o
);

  // Tree nodes in heap order: node 0 is the input, block k reads node k and
  // drives nodes 2k+1 (a) and 2k+2 (b). Blocks 0..6 cover layers 1..3, and
  // the leaves land in nodes 7..14 in output order.
  localparam int NUM_NODES = 2 * NUM_OUTPUTS - 1;
  localparam int LEAF_BASE = NUM_OUTPUTS - 1;

  logic [INPUT_WIDTH-1:0] node [NUM_NODES];

  assign node[0] = x_in_i;

  for (genvar lay = 0; lay < NUM_LAYERS; lay++) begin : g_layer
    for (genvar k = 0; k < (1 << lay); k++) begin : g_block
      localparam int IDX = (1 << lay) - 1 + k;

      switching_block #(
        .BLOCK_INDEX(IDX)
      ) u_block (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .x_i    (node[IDX]),
        .a_o    (node[2*IDX+1]),
        .b_o    (node[2*IDX+2])
      );
    end
  end

  assign x_out3_1_o = node[LEAF_BASE + 0];
  assign x_out3_2_o = node[LEAF_BASE + 1];
  assign x_out3_3_o = node[LEAF_BASE + 2];
  assign x_out3_4_o = node[LEAF_BASE + 3];
  assign x_out3_5_o = node[LEAF_BASE + 4];
  assign x_out3_6_o = node[LEAF_BASE + 5];
  assign x_out3_7_o = node[LEAF_BASE + 6];
  assign x_out3_8_o = node[LEAF_BASE + 7];

endmodule

// File: tb/tb_switching_block_layers.sv
// -----------------------------------------------------------------------------
// tb_switching_block_layers
//   Self-checking bench for switching_block_layers. Directed vectors from the
//   test plan plus 1000 random cycles. Sum and +/-1 spread are checked in both
//   builds; the toggle build is additionally checked leaf-by-leaf against a
//   tree model that applies the halving rule with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_switching_block_layers;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x;
  logic [15:0] y [8];

  int n_checks = 0;
  int n_fail   = 0;

  // history of inputs as seen at each edge (zeros stand in for flushed slots)
  int hist [$];

  // tree model (toggle mode): layer contents and sign bits
  int m1 [2];
  int m2 [4];
  int m3 [8];
  bit t1;
  bit t2 [2];
  bit t3 [4];

  always #5 clk = ~clk;

  switching_block_layers dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .x_in_i    (x),
    .x_out3_1_o(y[0]),
    .x_out3_2_o(y[1]),
    .x_out3_3_o(y[2]),
    .x_out3_4_o(y[3]),
    .x_out3_5_o(y[4]),
    .x_out3_6_o(y[5]),
    .x_out3_7_o(y[6]),
    .x_out3_8_o(y[7])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Halving rule: odd remainder goes to a when sign is 0, then sign flips.
  task automatic split(input int v, inout bit t, output int a, output int b);
    if (v % 2 == 0) begin
      a = v / 2;
      b = v / 2;
    end else if (!t) begin
      a = (v + 1) / 2;
      b = (v - 1) / 2;
      t = 1'b1;
    end else begin
      a = (v - 1) / 2;
      b = (v + 1) / 2;
      t = 1'b0;
    end
  endtask

  task automatic model_edge();
    int n1 [2];
    int n2 [4];
    int n3 [8];
    if (reset) begin
      m1 = '{default: 0};
      m2 = '{default: 0};
      m3 = '{default: 0};
      t1 = 1'b0;
      t2 = '{default: 1'b0};
      t3 = '{default: 1'b0};
      hist.delete();
      repeat (3) hist.push_back(0);
    end else begin
      for (int j = 0; j < 4; j++) split(m2[j], t3[j], n3[2*j], n3[2*j+1]);
      for (int j = 0; j < 2; j++) split(m1[j], t2[j], n2[2*j], n2[2*j+1]);
      split(int'(x), t1, n1[0], n1[1]);
      m1 = n1;
      m2 = n2;
      m3 = n3;
      hist.push_back(int'(x));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag, input int exp);
    for (int i = 0; i < 8; i++) check(tag, int'(y[i]), exp);
  endtask

  // Sum, spread and (toggle build) exact leaf values against the model.
  task automatic check_outputs(input string tag);
    int sum, lo, hi, mn, mx, src;
    src = hist[hist.size() - 3];
    sum = 0;
    mn  = 1 << 20;
    mx  = -1;
    lo  = src / 8;
    hi  = lo + 1;
    for (int i = 0; i < 8; i++) begin
      sum += int'(y[i]);
      if (int'(y[i]) < mn) mn = int'(y[i]);
      if (int'(y[i]) > mx) mx = int'(y[i]);
`ifndef DEM_LFSR_EN
      check({tag, "_leaf"}, int'(y[i]), m3[i]);
`endif
    end
    check({tag, "_sum"}, sum % 65536, src);
    check({tag, "_lo"}, int'(mn >= lo), 1);
    check({tag, "_hi"}, int'(mx <= hi), 1);
    check({tag, "_spread"}, int'(mx - mn <= 1), 1);
  endtask

  int vec_in  [6] = '{25000, 65000, 10000, 35000, 20536, 50000};
  int vec_exp [6] = '{3125, 8125, 1250, 4375, 2567, 6250};
  int pat7    [8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    reset = 1'b1;
    x     = '0;
    repeat (2) tick();
    check_all("reset", 0);

    // first sample after reset: zeros for two edges, then the split value
    reset = 1'b0;
    x     = 16'd50000;
    tick();
    check_all("fill1", 0);
    tick();
    check_all("fill2", 0);
    tick();
    check_all("x50000", 6250);

    for (int v = 0; v < 6; v++) begin
      x = (v == 4) ? 16'(-45000) : 16'(vec_in[v]);
      repeat (3) tick();
      check_all($sformatf("x%0d", vec_in[v]), vec_exp[v]);
    end

    // full-scale input: (x+1)/2 must not wrap
    x = 16'hFFFF;
    repeat (3) tick();
    check_outputs("fullscale");

    // odd input from reset: first valid pattern, then sum/spread every cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    x     = 16'd7;
    repeat (3) tick();
`ifndef DEM_LFSR_EN
    for (int i = 0; i < 8; i++) check("x7_first", int'(y[i]), pat7[i]);
`endif
    check_outputs("x7_first");
    repeat (12) begin
      tick();
      check_outputs("x7_hold");
    end

    // mid-stream reset discards in-flight samples
    x = 16'd12345;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_all("mid_reset", 0);
    reset = 1'b0;
    x     = 16'd25000;
    tick();
    check_all("post_reset1", 0);
    tick();
    check_all("post_reset2", 0);
    tick();
    check_all("post_reset3", 3125);

    // random stream
    for (int n = 0; n < 1000; n++) begin
      x = 16'($urandom);
      tick();
      check_outputs("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
